// File: rtl/router_demux_ctrl.sv
// Single-source to NUM_DST-destination packet demux with a one-beat output stage.
// Optional ROUTER_DEMUX_DROP_EN: discard packets whose dest-id is out of range.
module router_demux_ctrl #(
  parameter int WIDTH   = 64,
  parameter int NUM_DST = 4,
  parameter int DST_W   = 2,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               empty,
  output logic               pop,
  output logic [WIDTH-1:0]   data_out,
  output logic [NUM_DST-1:0] push,
  input  logic [NUM_DST-1:0] full,
  output logic               busy,
  output logic [15:0]        pkt_cnt
`ifdef ROUTER_DEMUX_DROP_EN
  ,
  output logic [15:0]        drop_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BODY,
    S_DROP
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_rem;
  logic [DST_W-1:0] r_dst;
  logic             r_stg_v;
  logic [WIDTH-1:0] r_stg_d;
  logic [DST_W-1:0] r_stg_dst;
  logic             r_stg_last;
  logic [15:0]      r_pkt_cnt;
`ifdef ROUTER_DEMUX_DROP_EN
  logic [15:0]      r_drop_cnt;
`endif

  logic [DST_W-1:0] w_hdr_raw;
  logic [LEN_W-1:0] w_hdr_len;
  logic             w_hdr_oor;
  logic [DST_W-1:0] w_hdr_dst;
  logic             w_hdr_drop;
  logic             w_fire;
  logic             w_can_load;
  logic             w_pop_ok;
  logic             w_dropping;
  logic             w_load;
  logic             w_idle;

  assign w_hdr_raw = data_in[DST_W-1:0];
  assign w_hdr_len = data_in[DST_W+LEN_W-1:DST_W];
  assign w_idle    = (r_state == S_IDLE);

  generate
    if ((1 << DST_W) > NUM_DST) begin : g_oor
      assign w_hdr_oor = (w_hdr_raw > DST_W'(NUM_DST - 1));
    end else begin : g_no_oor
      assign w_hdr_oor = 1'b0;
    end
  endgenerate

`ifdef ROUTER_DEMUX_DROP_EN
  assign w_hdr_drop = w_hdr_oor;
`else
  assign w_hdr_drop = 1'b0;
`endif

  // Without dropping, out-of-range ids fall back to destination 0
  assign w_hdr_dst = w_hdr_oor ? '0 : w_hdr_raw;

  always_comb begin
    push = '0;
    for (int i = 0; i < NUM_DST; i++) begin
      push[i] = r_stg_v && (r_stg_dst == DST_W'(i)) && !full[i];
    end
  end

  assign w_fire     = |push;
  assign w_can_load = !r_stg_v || w_fire;

  always_comb begin
    w_pop_ok = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): w_pop_ok = w_hdr_drop || w_can_load;
      (r_state == S_BODY): w_pop_ok = w_can_load;
      (r_state == S_DROP): w_pop_ok = 1'b1;
      default:             w_pop_ok = 1'b0;
    endcase
  end

  assign pop        = !reset && !empty && w_pop_ok;
  assign w_dropping = (r_state == S_DROP) || (w_idle && w_hdr_drop);
  assign w_load     = pop && !w_dropping;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_dst      <= '0;
      r_stg_v    <= 1'b0;
      r_stg_d    <= '0;
      r_stg_dst  <= '0;
      r_stg_last <= 1'b0;
      r_pkt_cnt  <= '0;
`ifdef ROUTER_DEMUX_DROP_EN
      r_drop_cnt <= '0;
`endif
    end else begin
      if (w_load) begin
        r_stg_v    <= 1'b1;
        r_stg_d    <= data_in;
        r_stg_dst  <= w_idle ? w_hdr_dst : r_dst;
        r_stg_last <= w_idle ? (w_hdr_len == '0)
                             : (r_rem == LEN_W'(1));
      end else if (w_fire) begin
        r_stg_v <= 1'b0;
      end

      if (w_fire && r_stg_last) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end

      if (pop) begin
        unique case (r_state)
          S_IDLE: begin
            r_dst <= w_hdr_dst;
            r_rem <= w_hdr_len;
`ifdef ROUTER_DEMUX_DROP_EN
            if (w_hdr_drop) begin
              if (w_hdr_len == '0) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
              end else begin
                r_state <= S_DROP;
              end
            end else
`endif
            if (w_hdr_len != '0) begin
              r_state <= S_BODY;
            end
          end
          S_BODY: begin
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) begin
              r_state <= S_IDLE;
            end
          end
          S_DROP: begin
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) begin
              r_state <= S_IDLE;
`ifdef ROUTER_DEMUX_DROP_EN
              r_drop_cnt <= r_drop_cnt + 16'd1;
`endif
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign data_out = r_stg_d;
  assign busy     = !w_idle || r_stg_v;
  assign pkt_cnt  = r_pkt_cnt;
`ifdef ROUTER_DEMUX_DROP_EN
  assign drop_cnt = r_drop_cnt;
`endif

endmodule
